irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Upstream feeder for the 8-to-3 priority encode path.
- Captures rising edges on 8 request lines into a sticky pending register and applies a per-line enable mask.
- Presents the highest-priority pending, enabled line as a registered interrupt ID to a consumer.
- Runs a request/acknowledge/end-of-interrupt handshake so each event is serviced exactly once.

Parameters:
- REQ_W, 8, number of request lines. Fixed at 8 for this revision.
- ID_W, 3, width of the interrupt ID. Equals log2(REQ_W).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  level request lines, already synchronous to clk. Bit 7 has the highest priority.
- mask  input  8  per-line enable. 1 = line may raise irq.
- clr_all  input  1  synchronous flush of all pending state.
- ack  input  1  consumer accepts the presented ID.
- eoi  input  1  consumer finished servicing.
- irq  output  1  interrupt valid.
- irq_id  output  3  ID of the presented line. Valid only while irq=1.
- pending  output  8  raw pending register, unmasked.
- busy  output  1  a serviced interrupt is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, req_d=0, state=IDLE.
  - irq=0, irq_id=0, busy=0.
  - Because req_d resets to 0, a req bit held high at reset release counts as an edge in the first clock.
- Edge detect:
  - req_d <= req every cycle.
  - edge = req & ~req_d.
  - pending[i] sets on edge[i], independent of mask. Masked lines stay pending and are served once unmasked.
- Candidate: cand = pending & mask. The highest set bit of cand wins (combinational encoder).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE:
    - If cand != 0: register the winning ID into irq_id, go to REQ.
    - irq is registered. Latency is req edge at clock t -> pending at t+1 -> irq=1 at t+2.
  - REQ:
    - irq=1. irq_id is frozen, with no preemption by later higher-priority edges.
    - On ack=1: clear pending[irq_id], go to SERVICE, irq=0 next cycle, busy=1.
    - If pending[irq_id]&mask[irq_id] goes 0 without ack (mask change): go to IDLE, irq=0 next cycle. The ID is re-evaluated from IDLE.
  - SERVICE:
    - busy=1, irq=0. New edges still set pending.
    - On eoi=1: go to IDLE, busy=0. The earliest next irq is 1 cycle after returning to IDLE.
- Ignored inputs: ack outside REQ, eoi outside SERVICE, and ack and eoi asserted together in REQ (ack acts, eoi ignored).
- Same-cycle set and clear: if an edge and an ack-clear hit the same bit in one cycle, set wins and the bit stays pending as a new event.
- clr_all (any state):
  - Next cycle: pending=0, state=IDLE, irq=0, busy=0.
  - Edges in the same cycle are dropped, so clr_all wins.
  - clr_all has priority over ack and eoi.
- Reset mid-operation: immediate return to reset values, with no completion of an outstanding handshake.
- All outputs are registered. pending is a direct register output.

Decomposition:
- Shared package / header:
  - REQ_W=8, ID_W=3.
  - State encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_SERVICE=2'd2.
- Sub-module: irq_prio_enc.
  - Combinational, 8-bit in -> 3-bit ID plus any-valid.
  - Highest-index bit wins. ID=0 and valid=0 when the input is all-zero.
  - Instantiated once on cand.

Test Plan:
1. Reset release with req=8'h00, mask=8'hFF, then pulse req[3] for 1 cycle -> pending=8'h08 one cycle later, irq=1 and irq_id=3 two cycles after the edge. ack -> pending=0, busy=1, irq=0. eoi -> busy=0, IDLE.
2. req edges on bits 1 and 6 in the same cycle -> irq_id=6. After ack/eoi, irq_id=1 is presented next with no new edge. pending goes 8'h42 -> 8'h02 -> 8'h00.
3. In REQ with irq_id=2, an edge on bit 7 arrives -> irq_id stays 2 until ack. After eoi, irq_id=7.
4. mask=8'hF7, edge on bit 3 -> pending=8'h08, irq stays 0. Set mask=8'hFF -> irq=1, irq_id=3 after 1 cycle.
5. In REQ with irq_id=5, ack asserted in the same cycle as a new edge on bit 5 -> pending[5] stays 1, SERVICE entered. After eoi, irq_id=5 is presented again.
6. clr_all asserted in SERVICE with pending=8'h81 and a concurrent edge on bit 4 -> next cycle pending=0, irq=0, busy=0, IDLE. Also: rst_n dropped mid-REQ -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared widths and FSM encoding for the interrupt pending controller.
package irq_pending_ctrl_pkg;

  localparam int REQ_W = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the highest set input bit wins.
// The output ID is 0 and valid is 0 when the input is all-zero.
module irq_prio_enc
  import irq_pending_ctrl_pkg::*;
(
  input  logic [REQ_W-1:0] in,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    id    = '0;
    valid = |in;
    // The loop runs upward, so a higher set bit overwrites a lower one.
    for (int i = 0; i < REQ_W; i++) begin
      if (in[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky rising-edge pending register with per-line mask, feeding a
// registered interrupt ID through a req/ack/eoi servicing handshake.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  input  logic [REQ_W-1:0] mask,
  input  logic             clr_all,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [REQ_W-1:0] pending,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [REQ_W-1:0] pending_q, pending_d;
  logic [REQ_W-1:0] req_d;
  logic [REQ_W-1:0] req_edge;
  logic [REQ_W-1:0] ack_clr;
  logic [REQ_W-1:0] cand;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             irq_q, busy_q;

  assign req_edge = req & ~req_d;
  assign cand     = pending_q & mask;

  irq_prio_enc u_enc (
    .in    (cand),
    .id    (win_id),
    .valid (win_valid)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack_clr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d  = ST_REQ;
          irq_id_d = win_id;
        end
      end
      ST_REQ: begin
        if (ack) begin
          ack_clr[irq_id_q] = 1'b1;
          state_d           = ST_SERVICE;
        end else if (!cand[irq_id_q]) begin
          // Presented line was masked off before ack: re-arbitrate from IDLE.
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr_all) state_d = ST_IDLE;

    // A new edge on the acked bit re-sets it, so it stays pending as a new event.
    pending_d = clr_all ? '0 : ((pending_q & ~ack_clr) | req_edge);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      pending_q <= '0;
      req_d     <= '0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      req_d     <= req;
      irq_q     <= (state_d == ST_REQ);
      busy_q    <= (state_d == ST_SERVICE);
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed self-checking bench for irq_pending_ctrl with hand-computed expectations.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       clr_all;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .clr_all (clr_all),
    .ack     (ack),
    .eoi     (eoi),
    .irq     (irq),
    .irq_id  (irq_id),
    .pending (pending),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the current inputs, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e_irq, input logic [2:0] e_id,
                         input logic [7:0] e_pend, input logic e_busy);
    check({tag, ".irq"}, {31'd0, irq}, {31'd0, e_irq});
    if (e_irq) check({tag, ".irq_id"}, {29'd0, irq_id}, {29'd0, e_id});
    check({tag, ".pending"}, {24'd0, pending}, {24'd0, e_pend});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
  endtask

  // Accept the presented interrupt and finish it, leaving the FSM in IDLE.
  task automatic ack_eoi();
    ack = 1'b1; step(); ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; mask = 8'hFF; clr_all = 1'b0; ack = 1'b0; eoi = 1'b0;
    #12;
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    check("reset.irq_id", {29'd0, irq_id}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 1: single pulse on bit 3 through the full handshake
    req = 8'h08; step();
    chk_out("t1.pend", 1'b0, 3'd0, 8'h08, 1'b0);
    req = 8'h00; step();
    chk_out("t1.irq", 1'b1, 3'd3, 8'h08, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    chk_out("t1.ack", 1'b0, 3'd0, 8'h00, 1'b1);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk_out("t1.eoi", 1'b0, 3'd0, 8'h00, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    chk_out("t1.stray_ack", 1'b0, 3'd0, 8'h00, 1'b0);

    // 2: simultaneous edges on 1 and 6, served highest first
    req = 8'h42; step(); req = 8'h00;
    chk_out("t2.pend", 1'b0, 3'd0, 8'h42, 1'b0);
    step();
    chk_out("t2.irq6", 1'b1, 3'd6, 8'h42, 1'b0);
    ack = 1'b1; eoi = 1'b1; step(); ack = 1'b0; eoi = 1'b0;
    chk_out("t2.ack6_eoi_ignored", 1'b0, 3'd0, 8'h02, 1'b1);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk_out("t2.eoi6", 1'b0, 3'd0, 8'h02, 1'b0);
    step();
    chk_out("t2.irq1", 1'b1, 3'd1, 8'h02, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    chk_out("t2.ack1", 1'b0, 3'd0, 8'h00, 1'b1);
    eoi = 1'b1; step(); eoi = 1'b0;

    // 3: no preemption while in REQ
    req = 8'h04; step(); req = 8'h00; step();
    chk_out("t3.irq2", 1'b1, 3'd2, 8'h04, 1'b0);
    req = 8'h80; step(); req = 8'h00;
    chk_out("t3.frozen", 1'b1, 3'd2, 8'h84, 1'b0);
    step();
    chk_out("t3.still2", 1'b1, 3'd2, 8'h84, 1'b0);
    ack_eoi();
    chk_out("t3.idle", 1'b0, 3'd0, 8'h80, 1'b0);
    step();
    chk_out("t3.irq7", 1'b1, 3'd7, 8'h80, 1'b0);
    ack_eoi();

    // 4: masked line stays pending, served once unmasked
    mask = 8'hF7; req = 8'h08; step(); req = 8'h00;
    chk_out("t4.pend", 1'b0, 3'd0, 8'h08, 1'b0);
    step(); step();
    chk_out("t4.masked", 1'b0, 3'd0, 8'h08, 1'b0);
    mask = 8'hFF; step();
    chk_out("t4.unmask", 1'b1, 3'd3, 8'h08, 1'b0);
    // mask drops while in REQ: back to IDLE, then re-presented on unmask
    mask = 8'hF7; step();
    chk_out("t4.withdrawn", 1'b0, 3'd0, 8'h08, 1'b0);
    mask = 8'hFF; step();
    chk_out("t4.reraise", 1'b1, 3'd3, 8'h08, 1'b0);
    ack_eoi();

    // 5: edge and ack-clear on the same bit: set wins
    req = 8'h20; step(); req = 8'h00; step();
    chk_out("t5.irq5", 1'b1, 3'd5, 8'h20, 1'b0);
    req = 8'h20; ack = 1'b1; step(); req = 8'h00; ack = 1'b0;
    chk_out("t5.setwins", 1'b0, 3'd0, 8'h20, 1'b1);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk_out("t5.eoi", 1'b0, 3'd0, 8'h20, 1'b0);
    step();
    chk_out("t5.irq5_again", 1'b1, 3'd5, 8'h20, 1'b0);
    ack_eoi();

    // 6a: clr_all in SERVICE beats a concurrent edge
    req = 8'h02; step(); req = 8'h00; step();
    ack = 1'b1; step(); ack = 1'b0;
    req = 8'h81; step();
    chk_out("t6.service", 1'b0, 3'd0, 8'h81, 1'b1);
    req = 8'h10; clr_all = 1'b1; step(); clr_all = 1'b0; req = 8'h00;
    chk_out("t6.clr", 1'b0, 3'd0, 8'h00, 1'b0);
    step();
    chk_out("t6.after_clr", 1'b0, 3'd0, 8'h00, 1'b0);

    // 6b: asynchronous reset mid-REQ
    req = 8'h08; step(); req = 8'h00; step();
    chk_out("t6.req", 1'b1, 3'd3, 8'h08, 1'b0);
    #2 rst_n = 1'b0; #1;
    chk_out("t6.async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    check("t6.async_rst.irq_id", {29'd0, irq_id}, 32'd0);

    // req held high across reset release counts as an edge
    req = 8'h01;
    @(negedge clk); rst_n = 1'b1;
    step();
    chk_out("rel.edge", 1'b0, 3'd0, 8'h01, 1'b0);
    step();
    chk_out("rel.irq0", 1'b1, 3'd0, 8'h01, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
